dmem_arbiter: RTL

- Shares the single data-memory port (clk, data_wr, data_addr, data_in, data_out) between two requesters.
- Requester A is the pipeline MEM stage (core). Requester B is a DMA/loader engine that preloads and dumps data memory without halting simulation.
- Core has default priority. A starvation counter and a locked-burst mode bound DMA latency.
- The core is held through a stall output, so the pipeline never loses an access.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester channels and the data-memory port of dmem_arbiter.
// Latency: none (wires only). Backpressure: the core is held through core_stall; DMA sees dma_gnt.
// Modports: slave = arbiter view (requests in, grants/memory drive out),
//           master = requester/memory view (the opposite directions).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core requester (pipeline MEM stage)
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  // DMA / loader requester
  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_gnt;
  // single data-memory port (combinational read, write on next edge)
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_rdata, dma_gnt,
    output mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_rdata, dma_gnt,
    input  mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (default priority) and a DMA engine.
// Latency: zero; grant, address mux and read data are combinational in the granted cycle.
// Backpressure: a denied core is frozen by core_stall; a denied DMA simply sees dma_gnt=0.
// Ports: clk, nrst (async active-low) and bus (dmem_arbiter_if.slave) carrying both
//        requester channels plus the memory port.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,   // 1..255
  parameter int MAX_BURST  = 8    // 1..255
) (
  input  logic             clk,
  input  logic             nrst,
  dmem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_CORE  = 2'd0,
    S_BURST = 2'd1,
    S_FAIR  = 2'd2
  } state_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0] BURST_LIM  = 8'(MAX_BURST);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic core_gnt_raw, dma_gnt_raw;
  logic core_gnt, dma_gnt;
  logic starve;

  // Next state and raw grants
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    core_gnt_raw = 1'b0;
    dma_gnt_raw  = 1'b0;
    starve       = 1'b0;

    unique case (state_q)
      S_CORE: begin
        // A saturated wait counter overrides core priority for one cycle.
        starve = bus.dma_req && (wait_cnt_q == STARVE_LIM);
        if (starve) begin
          dma_gnt_raw = 1'b1;
        end else if (bus.core_req) begin
          core_gnt_raw = 1'b1;
        end else if (bus.dma_req) begin
          dma_gnt_raw = 1'b1;
        end

        if (dma_gnt_raw && bus.dma_lock) begin
          state_d    = S_BURST;
          beat_cnt_d = 8'd1;
        end else if (starve) begin
          state_d = S_FAIR;
        end
      end

      S_BURST: begin
        if (bus.dma_req && bus.dma_lock && (beat_cnt_q < BURST_LIM)) begin
          dma_gnt_raw = 1'b1;
          beat_cnt_d  = beat_cnt_q + 8'd1;
        end else begin
          // Exit cycle: no burst beat. Arbitrate as the fair cycle would,
          // except a still-locked DMA request is not served here.
          core_gnt_raw = bus.core_req;
          dma_gnt_raw  = bus.dma_req && !bus.dma_lock && !bus.core_req;
          state_d      = S_FAIR;
          beat_cnt_d   = 8'd0;
        end
      end

      S_FAIR: begin
        // Single cycle in which the core always beats DMA.
        core_gnt_raw = bus.core_req;
        dma_gnt_raw  = bus.dma_req && !bus.core_req;
        state_d      = S_CORE;
      end

      default: begin
        state_d    = S_CORE;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // Grants are killed immediately while reset is asserted, even mid-burst.
  assign core_gnt = core_gnt_raw && nrst;
  assign dma_gnt  = dma_gnt_raw  && nrst;

  // Starvation counter: counts consecutive denied DMA cycles, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.dma_req || dma_gnt) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < STARVE_LIM) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_CORE;
      wait_cnt_q <= 8'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Memory port mux: core owns the port whenever DMA is not granted.
  assign bus.mem_addr  = dma_gnt ? bus.dma_addr  : bus.core_addr;
  assign bus.mem_wdata = dma_gnt ? bus.dma_wdata : bus.core_wdata;
  assign bus.mem_wr    = (core_gnt && bus.core_we) || (dma_gnt && bus.dma_we);

  assign bus.core_rdata = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;

  // nrst term keeps stall low during reset even though core_gnt is also low.
  assign bus.core_stall = nrst && bus.core_req && !core_gnt;
  assign bus.dma_gnt    = dma_gnt;

endmodule
